// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers of the MIPS core.
//
// MULT/MULTU produce a full 2*WIDTH product (HI = upper half, LO = lower
// half). DIV/DIVU produce LO = quotient and HI = remainder; signed division
// truncates toward zero and the remainder follows the sign of the dividend.
// Divide by zero returns HI = a, LO = all ones. MTHI/MTLO writes are taken
// only when idle and not starting an operation.
//
// Latency: start accepted at edge E0 -> busy_o high for WIDTH+1 cycles, then
// HI/LO update together with a one-cycle done_o pulse while busy_o falls.
//
// Handshake: start_i is a request sampled only in IDLE; busy_o doubles as the
// "not ready" indication, so a start_i seen while busy_o is high is dropped,
// never queued. done_o marks the single cycle in which new HI/LO appear.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start_i   in   launch operation (sampled only in IDLE)
//   op_i      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i       in   operand A (rs)
//   b_i       in   operand B (rt)
//   hi_we_i   in   MTHI write enable
//   lo_we_i   in   MTLO write enable
//   wdata_i   in   MTHI/MTLO write data
//   busy_o    out  operation in progress (registered)
//   done_o    out  one-cycle pulse, HI/LO just updated (registered)
//   hi_o      out  HI register
//   lo_o      out  LO register
//   state_o   out  current FSM state (debug visibility)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_res_q;   // negate product / quotient in FIX
  logic             neg_rem_q;   // negate remainder in FIX
  logic             div0_q;      // divisor was zero
  logic [WIDTH-1:0] b_q;         // multiplicand or divisor magnitude
  logic [WIDTH-1:0] ah_q;        // product upper half / partial remainder
  logic [WIDTH-1:0] al_q;        // multiplier -> product lower half / dividend -> quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  // Operand preparation at the accepting edge.
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  always_comb begin
    op_signed = ~op_i[0];
    op_div    = op_i[1];
    a_neg     = op_signed & a_i[WIDTH-1];
    b_neg     = op_signed & b_i[WIDTH-1];
    a_abs     = a_neg ? (~a_i + 1'b1) : a_i;
    b_abs     = b_neg ? (~b_i + 1'b1) : b_i;
  end

  // One iteration step and the final sign correction.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [WIDTH-1:0]   ah_d;
  logic [WIDTH-1:0]   al_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  always_comb begin
    // Shift-add: conditionally add the multiplicand to the upper half, then
    // shift the {carry, upper, lower} chain right by one.
    mul_sum = {1'b0, ah_q} + (al_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    // Restoring divide: shift the next dividend bit into the partial
    // remainder and subtract the divisor only when it fits. The remainder
    // stays below the divisor, so WIDTH bits always hold it.
    div_sh  = {ah_q, al_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, b_q});
    div_sub = div_sh[WIDTH-1:0] - b_q;

    if (is_div_q) begin
      ah_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
      al_d = {al_q[WIDTH-2:0], div_ge};
    end else begin
      ah_d = mul_sum[WIDTH:1];
      al_d = {mul_sum[0], al_q[WIDTH-1:1]};
    end

    prod_fix = neg_res_q ? (~{ah_q, al_q} + 1'b1) : {ah_q, al_q};
    quot_fix = div0_q ? {WIDTH{1'b1}} : (neg_res_q ? (~al_q + 1'b1) : al_q);
    rem_fix  = neg_rem_q ? (~ah_q + 1'b1) : ah_q;

    if (is_div_q) begin
      hi_d = rem_fix;
      lo_d = quot_fix;
    end else begin
      hi_d = prod_fix[2*WIDTH-1:WIDTH];
      lo_d = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      b_q       <= '0;
      ah_q      <= '0;
      al_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // start takes priority; any MTHI/MTLO in this cycle is dropped.
            state_q   <= S_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op_div;
            // A zero divisor keeps the all-ones quotient unsigned; the
            // remainder path then hands back the original dividend.
            neg_res_q <= (a_neg ^ b_neg) & ~(op_div & (b_i == '0));
            neg_rem_q <= op_div & a_neg;
            div0_q    <= op_div & (b_i == '0);
            b_q       <= b_abs;
            ah_q      <= '0;
            al_q      <= a_abs;
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        S_CALC: begin
          ah_q  <= ah_d;
          al_q  <= al_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed operations with hand-computed HI/LO,
// a scoreboard queue filled at issue time and drained by a done_o monitor.
module tb_muldiv_unit;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         hi_we_i;
  logic         lo_we_i;
  logic [W-1:0] wdata_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic [1:0]   state_o;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .state_o (state_o)
  );

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_exp;
  logic           prev_done = 1'b0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width got done high two cycles, required one-cycle pulse");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got hi=%h lo=%h, required no done", hi_o, lo_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({hi_o, lo_o} !== mon_exp) begin
          errors++;
          $display("FAIL result got hi=%h lo=%h required hi=%h lo=%h",
                   hi_o, lo_o, mon_exp[2*W-1:W], mon_exp[W-1:0]);
        end
      end
    end
    prev_done = (rst_n === 1'b1) && (done_o === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Counts negedges with busy high, starting at the current negedge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int n;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    exp_q.push_back({exp_hi, exp_lo});
    @(negedge clk);
    start_i = 1'b0;
    a_i = $urandom(); b_i = $urandom(); op_i = 2'($urandom_range(0, 3));
    wait_idle(n);
    chk("busy_cycles", 64'(n), 64'd33);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    chk("reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_state", 64'(state_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle MTHI + MTLO in the same cycle.
    @(negedge clk);
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_1234;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("idle_write", {hi_o, lo_o}, {32'h0000_1234, 32'h0000_1234});

    // start wins over a simultaneous MTHI; HI holds old value while busy.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd2; b_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'h0000_BEEF;
    exp_q.push_back({32'd0, 32'd6});
    @(negedge clk);
    start_i = 1'b0; hi_we_i = 1'b0;
    chk("start_wins_hold", {hi_o, lo_o}, {32'h0000_1234, 32'h0000_1234});
    chk("busy_after_start", 64'(busy_o), 64'd1);
    wait_idle(n);
    chk("busy_cycles", 64'(n), 64'd33);

    // Main function vectors.
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    do_op(OP_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003);
    do_op(OP_DIVU,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC);
    // Boundaries: divide by zero and signed overflow.
    do_op(OP_DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF);
    do_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // start and MTHI while busy are ignored.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_MULTU; a_i = 32'd3; b_i = 32'd4;
    exp_q.push_back({32'd0, 32'd12});
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1; op_i = OP_DIVU; a_i = 32'd9; b_i = 32'd3;
    hi_we_i = 1'b1; wdata_i = 32'h0000_DEAD;
    @(negedge clk);
    start_i = 1'b0; hi_we_i = 1'b0;
    chk("busy_ignore_hold", {hi_o, lo_o}, {32'h0000_0000, 32'h8000_0000});
    wait_idle(n);
    chk("busy_cycles_ignored", 64'(n), 64'd28);

    // Idle MTHI only: LO untouched.
    @(negedge clk);
    hi_we_i = 1'b1; wdata_i = 32'h0000_0055;
    @(negedge clk);
    hi_we_i = 1'b0;
    chk("idle_mthi_only", {hi_o, lo_o}, {32'h0000_0055, 32'd12});

    // Asynchronous reset mid-operation: no done, everything cleared.
    @(negedge clk);
    start_i = 1'b1; op_i = OP_DIV; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_reset_busy_done", {62'd0, busy_o, done_o}, 64'd0);
    chk("midop_reset_hilo", {hi_o, lo_o}, 64'd0);
    chk("midop_reset_state", 64'(state_o), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got no finish, required completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
